// File: rtl/id_ex_decode_stage_pkg.sv
// Shared RV32I opcode, ALU, writeback and control-flow encodings for the ID/EX decode stage.
package id_ex_decode_stage_pkg;

  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

  localparam logic [3:0] ALU_FUN_ADD    = 4'd0;
  localparam logic [3:0] ALU_FUN_SUB    = 4'd1;
  localparam logic [3:0] ALU_FUN_SLL    = 4'd2;
  localparam logic [3:0] ALU_FUN_SLT    = 4'd3;
  localparam logic [3:0] ALU_FUN_SLTU   = 4'd4;
  localparam logic [3:0] ALU_FUN_XOR    = 4'd5;
  localparam logic [3:0] ALU_FUN_SRL    = 4'd6;
  localparam logic [3:0] ALU_FUN_SRA    = 4'd7;
  localparam logic [3:0] ALU_FUN_OR     = 4'd8;
  localparam logic [3:0] ALU_FUN_AND    = 4'd9;
  localparam logic [3:0] ALU_FUN_COPY_B = 4'd10;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  localparam logic [1:0] CTRL_FLOW_NONE   = 2'b00;
  localparam logic [1:0] CTRL_FLOW_BRANCH = 2'b01;
  localparam logic [1:0] CTRL_FLOW_JAL    = 2'b10;
  localparam logic [1:0] CTRL_FLOW_JALR   = 2'b11;

  typedef enum logic [2:0] {ImmI, ImmS, ImmB, ImmU, ImmJ} imm_fmt_e;

  typedef struct packed {
    logic       illegal;
    logic [3:0] alu_fun;
    logic       op1_sel;
    logic       op2_sel;
    logic [1:0] wb_sel;
    logic       reg_we;
    logic       mem_val;
    logic       mem_rw;
    logic [1:0] ctrl_flow;
    logic [2:0] funct3;
  } ctrl_t;

  // alt selects SUB/SRA; callers gate it so ADDI with a negative immediate stays ADD.
  function automatic logic [3:0] alu_fun_of(logic [2:0] funct3, logic alt);
    logic [3:0] fun;
    case (funct3)
      3'b000:  fun = alt ? ALU_FUN_SUB : ALU_FUN_ADD;
      3'b001:  fun = ALU_FUN_SLL;
      3'b010:  fun = ALU_FUN_SLT;
      3'b011:  fun = ALU_FUN_SLTU;
      3'b100:  fun = ALU_FUN_XOR;
      3'b101:  fun = alt ? ALU_FUN_SRA : ALU_FUN_SRL;
      3'b110:  fun = ALU_FUN_OR;
      default: fun = ALU_FUN_AND;
    endcase
    return fun;
  endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational RV32I immediate generator; sign-extends the selected format to XLEN.
module rv_imm_gen
  import id_ex_decode_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    unique case (fmt)
      ImmS:    imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      ImmB:    imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      ImmU:    imm32 = {instr[31:12], 12'b0};
      ImmJ:    imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = {{20{instr[31]}}, instr[31:20]};
    endcase
  end

  always_comb begin
    imm       = {XLEN{imm32[31]}};
    imm[31:0] = imm32;
  end

endmodule

// File: rtl/id_ex_decode_stage.sv
// RV32I decode stage: decodes IF/ID instruction into a registered ID/EX control bundle,
// inserting one bubble on load-use hazards and honouring EX redirect flushes.
module id_ex_decode_stage
  import id_ex_decode_stage_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [31:0]       if_instr,
  input  logic [XLEN-1:0]   if_pc,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [3:0]        ex_alu_fun,
  output logic              ex_op1_sel,
  output logic              ex_op2_sel,
  output logic [1:0]        ex_wb_sel,
  output logic              ex_reg_we,
  output logic              ex_mem_val,
  output logic              ex_mem_rw,
  output logic [1:0]        ex_ctrl_flow,
  output logic [2:0]        ex_funct3,
  output logic [REG_AW-1:0] ex_rd,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_pc,
  output logic              ex_illegal,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [6:0]        opcode;
  logic [6:0]        funct7;
  logic [2:0]        funct3;
  logic [REG_AW-1:0] dec_rd, dec_rs1, dec_rs2;
  ctrl_t             dec_ctrl;
  imm_fmt_e          dec_fmt;
  logic              dec_uses_rs1, dec_uses_rs2;
  logic [XLEN-1:0]   dec_imm;

  assign opcode  = if_instr[6:0];
  assign funct3  = if_instr[14:12];
  assign funct7  = if_instr[31:25];
  assign dec_rd  = REG_AW'(if_instr[11:7]);
  assign dec_rs1 = REG_AW'(if_instr[19:15]);
  assign dec_rs2 = REG_AW'(if_instr[24:20]);

  always_comb begin
    dec_ctrl         = '0;
    dec_ctrl.funct3  = funct3;
    dec_fmt          = ImmI;
    dec_uses_rs1     = 1'b0;
    dec_uses_rs2     = 1'b0;
    unique case (opcode)
      OPCODE_LUI: begin
        dec_ctrl.alu_fun = ALU_FUN_COPY_B;
        dec_ctrl.op2_sel = 1'b1;
        dec_ctrl.reg_we  = 1'b1;
        dec_fmt          = ImmU;
      end
      OPCODE_AUIPC: begin
        dec_ctrl.op1_sel = 1'b1;
        dec_ctrl.op2_sel = 1'b1;
        dec_ctrl.reg_we  = 1'b1;
        dec_fmt          = ImmU;
      end
      OPCODE_JAL: begin
        dec_ctrl.op1_sel   = 1'b1;
        dec_ctrl.op2_sel   = 1'b1;
        dec_ctrl.wb_sel    = WB_SEL_PC4;
        dec_ctrl.reg_we    = 1'b1;
        dec_ctrl.ctrl_flow = CTRL_FLOW_JAL;
        dec_fmt            = ImmJ;
      end
      OPCODE_JALR: begin
        dec_ctrl.op2_sel   = 1'b1;
        dec_ctrl.wb_sel    = WB_SEL_PC4;
        dec_ctrl.reg_we    = 1'b1;
        dec_ctrl.ctrl_flow = CTRL_FLOW_JALR;
        dec_ctrl.illegal   = (funct3 != 3'b000);
        dec_uses_rs1       = 1'b1;
      end
      OPCODE_BRANCH: begin
        // ALU compares rs1/rs2; EX resolves the condition from funct3.
        dec_ctrl.alu_fun   = ALU_FUN_SUB;
        dec_ctrl.ctrl_flow = CTRL_FLOW_BRANCH;
        dec_ctrl.illegal   = (funct3 == 3'b010) || (funct3 == 3'b011);
        dec_fmt            = ImmB;
        dec_uses_rs1       = 1'b1;
        dec_uses_rs2       = 1'b1;
      end
      OPCODE_LOAD: begin
        dec_ctrl.op2_sel = 1'b1;
        dec_ctrl.wb_sel  = WB_SEL_MEM;
        dec_ctrl.reg_we  = 1'b1;
        dec_ctrl.mem_val = 1'b1;
        dec_ctrl.illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        dec_uses_rs1     = 1'b1;
      end
      OPCODE_STORE: begin
        dec_ctrl.op2_sel = 1'b1;
        dec_ctrl.mem_val = 1'b1;
        dec_ctrl.mem_rw  = 1'b1;
        dec_ctrl.illegal = funct3[2] || (funct3[1:0] == 2'b11);
        dec_fmt          = ImmS;
        dec_uses_rs1     = 1'b1;
        dec_uses_rs2     = 1'b1;
      end
      OPCODE_OP_IMM: begin
        dec_ctrl.alu_fun = alu_fun_of(funct3, (funct3 == 3'b101) && funct7[5]);
        dec_ctrl.op2_sel = 1'b1;
        dec_ctrl.reg_we  = 1'b1;
        dec_ctrl.illegal = ((funct3 == 3'b001) && (funct7 != 7'b0)) ||
                           ((funct3 == 3'b101) && ((funct7 & 7'b1011111) != 7'b0));
        dec_uses_rs1     = 1'b1;
      end
      OPCODE_OP: begin
        dec_ctrl.alu_fun = alu_fun_of(funct3, funct7[5]);
        dec_ctrl.reg_we  = 1'b1;
        dec_ctrl.illegal = (funct7 != 7'b0) &&
                           !((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        dec_uses_rs1     = 1'b1;
        dec_uses_rs2     = 1'b1;
      end
      OPCODE_MISC_MEM, OPCODE_SYSTEM: begin
        // FENCE/ECALL/EBREAK travel as no-ops with no architectural side effect here.
      end
      default: dec_ctrl.illegal = 1'b1;
    endcase
    if (dec_ctrl.illegal) begin
      dec_ctrl         = '0;
      dec_ctrl.funct3  = funct3;
      dec_ctrl.illegal = 1'b1;
      dec_fmt          = ImmI;
      dec_uses_rs1     = 1'b0;
      dec_uses_rs2     = 1'b0;
    end
    if (dec_rd == '0) dec_ctrl.reg_we = 1'b0;
  end

  rv_imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .instr (if_instr),
    .fmt   (dec_fmt),
    .imm   (dec_imm)
  );

  logic              valid_q, valid_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [REG_AW-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [XLEN-1:0]   imm_q, imm_d, pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              advance, hazard;

  assign advance = !valid_q || ex_ready;
  assign hazard  = if_valid && valid_q && ctrl_q.mem_val && !ctrl_q.mem_rw && (rd_q != '0) &&
                   ((dec_uses_rs1 && (dec_rs1 == rd_q)) || (dec_uses_rs2 && (dec_rs2 == rd_q)));
  assign if_ready = flush || (advance && !hazard);

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (advance && hazard) begin
      valid_d = 1'b0;
      cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    end else if (advance && if_valid) begin
      valid_d = 1'b1;
      ctrl_d  = dec_ctrl;
      rd_d    = dec_rd;
      rs1_d   = dec_rs1;
      rs2_d   = dec_rs2;
      imm_d   = dec_imm;
      pc_d    = if_pc;
    end else if (advance) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_alu_fun   = ctrl_q.alu_fun;
  assign ex_op1_sel   = ctrl_q.op1_sel;
  assign ex_op2_sel   = ctrl_q.op2_sel;
  assign ex_wb_sel    = ctrl_q.wb_sel;
  assign ex_reg_we    = ctrl_q.reg_we;
  assign ex_mem_val   = ctrl_q.mem_val;
  assign ex_mem_rw    = ctrl_q.mem_rw;
  assign ex_ctrl_flow = ctrl_q.ctrl_flow;
  assign ex_funct3    = ctrl_q.funct3;
  assign ex_illegal   = ctrl_q.illegal;
  assign ex_rd        = rd_q;
  assign ex_rs1       = rs1_q;
  assign ex_rs2       = rs2_q;
  assign ex_imm       = imm_q;
  assign ex_pc        = pc_q;
  assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_id_ex_decode_stage.sv
// Self-checking bench for id_ex_decode_stage: directed scenarios plus a scoreboard of
// expected ID/EX bundles built from an independent RV32I decode model.
module tb_id_ex_decode_stage;

  logic        clk = 1'b0;
  logic        rst, if_valid, flush, ex_ready;
  logic        if_ready;
  logic [31:0] if_instr, if_pc;
  logic        ex_valid, ex_op1_sel, ex_op2_sel, ex_reg_we, ex_mem_val, ex_mem_rw, ex_illegal;
  logic [3:0]  ex_alu_fun;
  logic [1:0]  ex_wb_sel, ex_ctrl_flow;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic [31:0] ex_imm, ex_pc, stall_cnt;

  int checks   = 0;
  int failures = 0;
  bit acc;

  typedef struct packed {
    logic        illegal;
    logic [3:0]  alu;
    logic        op1;
    logic        op2;
    logic [1:0]  wb;
    logic        we;
    logic        mval;
    logic        mrw;
    logic [1:0]  flow;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  id_ex_decode_stage dut (
    .clk          (clk),
    .rst          (rst),
    .if_valid     (if_valid),
    .if_ready     (if_ready),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .flush        (flush),
    .ex_ready     (ex_ready),
    .ex_valid     (ex_valid),
    .ex_alu_fun   (ex_alu_fun),
    .ex_op1_sel   (ex_op1_sel),
    .ex_op2_sel   (ex_op2_sel),
    .ex_wb_sel    (ex_wb_sel),
    .ex_reg_we    (ex_reg_we),
    .ex_mem_val   (ex_mem_val),
    .ex_mem_rw    (ex_mem_rw),
    .ex_ctrl_flow (ex_ctrl_flow),
    .ex_funct3    (ex_funct3),
    .ex_rd        (ex_rd),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .ex_imm       (ex_imm),
    .ex_pc        (ex_pc),
    .ex_illegal   (ex_illegal),
    .stall_cnt    (stall_cnt)
  );

  function automatic logic [3:0] ref_alu(logic [2:0] f3, logic alt);
    case (f3)
      3'd0: return alt ? 4'd1 : 4'd0;
      3'd1: return 4'd2;
      3'd2: return 4'd3;
      3'd3: return 4'd4;
      3'd4: return 4'd5;
      3'd5: return alt ? 4'd7 : 4'd6;
      3'd6: return 4'd8;
      default: return 4'd9;
    endcase
  endfunction

  function automatic exp_t model(logic [31:0] i, logic [31:0] pc);
    exp_t e;
    exp_t base;
    logic [2:0] f3;
    logic [6:0] f7;
    logic ill;
    f3 = i[14:12];
    f7 = i[31:25];
    ill = 1'b0;
    e = '0;
    e.f3 = f3;
    e.rd = i[11:7];
    e.rs1 = i[19:15];
    e.rs2 = i[24:20];
    e.pc = pc;
    e.imm = {{20{i[31]}}, i[31:20]};
    base = e;
    case (i[6:0])
      7'h37: begin e.alu = 4'd10; e.op2 = 1; e.we = 1; e.imm = {i[31:12], 12'h000}; end
      7'h17: begin e.op1 = 1; e.op2 = 1; e.we = 1; e.imm = {i[31:12], 12'h000}; end
      7'h6F: begin
        e.op1 = 1; e.op2 = 1; e.wb = 2'b10; e.we = 1; e.flow = 2'b10;
        e.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      end
      7'h67: begin
        ill = (f3 != 0);
        e.op2 = 1; e.wb = 2'b10; e.we = 1; e.flow = 2'b11;
      end
      7'h63: begin
        ill = (f3 == 2) || (f3 == 3);
        e.alu = 4'd1; e.flow = 2'b01;
        e.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      end
      7'h03: begin
        ill = (f3 == 3) || (f3 == 6) || (f3 == 7);
        e.op2 = 1; e.wb = 2'b01; e.mval = 1; e.we = 1;
      end
      7'h23: begin
        ill = (f3 > 2);
        e.op2 = 1; e.mval = 1; e.mrw = 1;
        e.imm = {{20{i[31]}}, i[31:25], i[11:7]};
      end
      7'h13: begin
        if (f3 == 1) ill = (f7 != 0);
        if (f3 == 5) ill = !((f7 == 7'h00) || (f7 == 7'h20));
        e.op2 = 1; e.we = 1; e.alu = ref_alu(f3, (f3 == 5) && (f7 == 7'h20));
      end
      7'h33: begin
        ill = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 0) || (f3 == 5))));
        e.we = 1; e.alu = ref_alu(f3, f7 == 7'h20);
      end
      7'h0F, 7'h73: ;
      default: ill = 1'b1;
    endcase
    if (ill) begin
      e = base;
      e.illegal = 1'b1;
    end
    if (e.rd == 0) e.we = 1'b0;
    return e;
  endfunction

  // One clock: scoreboard sampled at the negedge before the rising edge, then settle after it.
  task automatic clk_step(output bit accepted);
    exp_t exp_v, act_v;
    @(negedge clk);
    accepted = if_valid && if_ready && !flush && !rst;
    if (!rst) begin
      if (ex_valid && ex_ready) begin
        checks++;
        act_v = {ex_illegal, ex_alu_fun, ex_op1_sel, ex_op2_sel, ex_wb_sel, ex_reg_we, ex_mem_val,
                 ex_mem_rw, ex_ctrl_flow, ex_funct3, ex_rd, ex_rs1, ex_rs2, ex_imm, ex_pc};
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_output got=%h expected=<none>", act_v);
        end else begin
          exp_v = sb.pop_front();
          if (act_v !== exp_v) begin
            failures++;
            $display("FAIL sb_bundle got=%h expected=%h", act_v, exp_v);
          end
        end
      end else if (flush && ex_valid && sb.size() > 0) begin
        void'(sb.pop_front());
      end
      if (accepted) sb.push_back(model(if_instr, if_pc));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; if_valid = 0; flush = 0; ex_ready = 1; if_instr = 0; if_pc = 0;
    repeat (2) clk_step(acc);
    rst = 0;
    #1;
    checks++;
    if (ex_valid !== 1'b0) begin failures++; $display("FAIL reset_ex_valid got=%b expected=0", ex_valid); end
    checks++;
    if (if_ready !== 1'b1) begin failures++; $display("FAIL reset_if_ready got=%b expected=1", if_ready); end
    checks++;
    if (stall_cnt !== 32'd0) begin failures++; $display("FAIL reset_stall_cnt got=%0d expected=0", stall_cnt); end
    sb.delete();
  endtask

  task automatic test_addi();
    if_valid = 1; if_instr = 32'h00500093; if_pc = 32'h100; ex_ready = 1;
    clk_step(acc);
    if_valid = 0;
    #1;
    checks++;
    if ({ex_valid, ex_alu_fun, ex_op2_sel, ex_reg_we, ex_wb_sel, ex_rd} !== {1'b1, 4'd0, 1'b1, 1'b1, 2'b00, 5'd1}) begin
      failures++;
      $display("FAIL addi_ctrl got=v%b alu%0d op2%b we%b wb%b rd%0d expected=v1 alu0 op21 we1 wb00 rd1",
               ex_valid, ex_alu_fun, ex_op2_sel, ex_reg_we, ex_wb_sel, ex_rd);
    end
    checks++;
    if (ex_imm !== 32'd5) begin failures++; $display("FAIL addi_imm got=%h expected=00000005", ex_imm); end
    clk_step(acc);
  endtask

  task automatic test_load_use();
    if_valid = 1; if_instr = 32'h0000A103; if_pc = 32'h104; ex_ready = 1;
    clk_step(acc);
    if_instr = 32'h002101B3; if_pc = 32'h108;
    #1;
    checks++;
    if (if_ready !== 1'b0) begin failures++; $display("FAIL loaduse_if_ready got=%b expected=0", if_ready); end
    clk_step(acc);
    checks++;
    if (ex_valid !== 1'b0) begin failures++; $display("FAIL loaduse_bubble got=%b expected=0", ex_valid); end
    checks++;
    if (stall_cnt !== 32'd1) begin failures++; $display("FAIL loaduse_stall_cnt got=%0d expected=1", stall_cnt); end
    checks++;
    if (if_ready !== 1'b1) begin failures++; $display("FAIL loaduse_release got=%b expected=1", if_ready); end
    clk_step(acc);
    if_valid = 0;
    #1;
    checks++;
    if ({ex_valid, ex_alu_fun, ex_rd} !== {1'b1, 4'd0, 5'd3}) begin
      failures++;
      $display("FAIL loaduse_add got=v%b alu%0d rd%0d expected=v1 alu0 rd3", ex_valid, ex_alu_fun, ex_rd);
    end
    clk_step(acc);
  endtask

  task automatic test_branch_hold();
    logic [31:0] imm0, pc0;
    if_valid = 1; if_instr = 32'hFE000EE3; if_pc = 32'h200; ex_ready = 1;
    clk_step(acc);
    imm0 = ex_imm; pc0 = ex_pc;
    checks++;
    if ({ex_ctrl_flow, ex_reg_we, ex_imm} !== {2'b01, 1'b0, 32'hFFFFFFFC}) begin
      failures++;
      $display("FAIL branch_decode got=flow%b we%b imm%h expected=flow01 we0 immfffffffc",
               ex_ctrl_flow, ex_reg_we, ex_imm);
    end
    if_instr = 32'h00100093; if_pc = 32'h204; ex_ready = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({ex_valid, if_ready, ex_ctrl_flow, ex_imm, ex_pc} !== {1'b1, 1'b0, 2'b01, imm0, pc0}) begin
        failures++;
        $display("FAIL branch_hold cyc=%0d got=v%b rdy%b flow%b imm%h pc%h expected=v1 rdy0 flow01 imm%h pc%h",
                 c, ex_valid, if_ready, ex_ctrl_flow, ex_imm, ex_pc, imm0, pc0);
      end
      clk_step(acc);
    end
    ex_ready = 1;
    clk_step(acc);
    if_valid = 0;
    clk_step(acc);
  endtask

  task automatic test_flush_hazard();
    logic [31:0] cnt0;
    if_valid = 1; if_instr = 32'h0000A103; if_pc = 32'h300; ex_ready = 1;
    clk_step(acc);
    cnt0 = stall_cnt;
    if_instr = 32'h002101B3; if_pc = 32'h304; flush = 1;
    #1;
    checks++;
    if (if_ready !== 1'b1) begin failures++; $display("FAIL flush_if_ready got=%b expected=1", if_ready); end
    clk_step(acc);
    flush = 0; if_valid = 0;
    #1;
    checks++;
    if (ex_valid !== 1'b0) begin failures++; $display("FAIL flush_ex_valid got=%b expected=0", ex_valid); end
    checks++;
    if (stall_cnt !== cnt0) begin failures++; $display("FAIL flush_stall_cnt got=%0d expected=%0d", stall_cnt, cnt0); end
    clk_step(acc);
  endtask

  task automatic test_illegal();
    if_valid = 1; if_instr = 32'hFFFFFFFF; if_pc = 32'h400; ex_ready = 1;
    clk_step(acc);
    if_instr = 32'h00100013; if_pc = 32'h404;
    #1;
    checks++;
    if ({ex_valid, ex_illegal, ex_reg_we, ex_mem_val} !== 4'b1100) begin
      failures++;
      $display("FAIL illegal_ctrl got=v%b ill%b we%b mv%b expected=v1 ill1 we0 mv0",
               ex_valid, ex_illegal, ex_reg_we, ex_mem_val);
    end
    clk_step(acc);
    if_valid = 0;
    #1;
    checks++;
    if ({ex_valid, ex_illegal, ex_reg_we} !== 3'b100) begin
      failures++;
      $display("FAIL addi_x0_we got=v%b ill%b we%b expected=v1 ill0 we0", ex_valid, ex_illegal, ex_reg_we);
    end
    clk_step(acc);
  endtask

  task automatic test_back_to_back();
    logic [31:0] tbl [12];
    int idx, cyc;
    tbl = '{32'h123452B7, 32'h00001317, 32'h008000EF, 32'h00008067, 32'h0020A423, 32'h40208233,
            32'h4030D293, 32'h0020B333, 32'hFE308FA3, 32'hFFC12383, 32'h02208233, 32'h00738433};
    idx = 0; cyc = 0;
    while (idx < 12 && cyc < 400) begin
      if_valid = ($urandom_range(0, 3) != 0);
      if_instr = tbl[idx];
      if_pc = 32'h1000 + 32'(idx) * 4;
      ex_ready = ($urandom_range(0, 2) != 0);
      clk_step(acc);
      if (acc) idx++;
      cyc++;
    end
    if_valid = 0; ex_ready = 1;
    for (int c = 0; c < 8; c++) clk_step(acc);
    checks++;
    if (idx != 12 || sb.size() != 0) begin
      failures++;
      $display("FAIL stream_drain got=issued%0d pending%0d expected=issued12 pending0", idx, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    if_valid = 1; if_instr = 32'h00500093; if_pc = 32'h500; ex_ready = 0;
    clk_step(acc);
    if_valid = 0; rst = 1;
    clk_step(acc);
    rst = 0;
    sb.delete();
    #1;
    checks++;
    if ({ex_valid, stall_cnt} !== 33'd0) begin
      failures++;
      $display("FAIL reset_mid got=v%b cnt%0d expected=v0 cnt0", ex_valid, stall_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_use();
    test_branch_hold();
    test_flush_hazard();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
